alarm_sched_ctrl: RTL

Control and scheduling block for the alarm clock. It conditions the hour_up and min_up buttons into single-cycle increment strobes with auto-repeat. It steers those strobes either to the timekeeping counters (mode 1) or to its own alarm-time registers (mode 2). It also runs the alarm state machine: match, ring, snooze and dismiss. It sits between the board inputs and the time counter / display mux, and consumes the time counter's current value and 1 Hz strobe.

---
 rtl/alarm_sched_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alarm_sched_ctrl.sv
// Alarm clock control: button conditioning, set-mode steering
// and the ring / snooze / dismiss state machine.

module alarm_btn_cond #(
  parameter int REPEAT_DLY = 100,
  parameter int REPEAT_PER = 50
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(REPEAT_DLY + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // sync the raw button, strobe once on press, then auto-repeat
  // cnt==0 marks "no strobe issued yet for this hold"
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      pulse <= 1'b0;
      if (!s2) begin
        cnt <= '0;
      end else if (cnt == '0) begin
        pulse <= 1'b1;
        cnt   <= CW'(1);
      end else if (cnt == CW'(REPEAT_DLY)) begin
        pulse <= 1'b1;
        cnt   <= CW'(REPEAT_DLY - REPEAT_PER + 1);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module alarm_sched_ctrl #(
  parameter int REPEAT_DLY  = 100,
  parameter int REPEAT_PER  = 50,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick_1hz,
  input  logic [1:0] mode,
  input  logic       hour_up,
  input  logic       min_up,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       time_inc_hour,
  output logic       time_inc_min,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       armed,
  output logic       disp_alarm,
  output logic       alarm
);

  localparam int SMAX =
    (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int SW = $clog2(SMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZE
  } state_t;

  state_t        state;
  logic [SW-1:0] sec_cnt;
  logic          hour_p;
  logic          min_p;
  logic          any_p;
  logic          is_idle;
  logic          match;

  alarm_btn_cond #(
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER)
  ) u_hour (
    .clk  (clk),
    .clr  (clr),
    .btn  (hour_up),
    .pulse(hour_p)
  );

  alarm_btn_cond #(
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER)
  ) u_min (
    .clk  (clk),
    .clr  (clr),
    .btn  (min_up),
    .pulse(min_p)
  );

  assign any_p   = hour_p | min_p;
  assign is_idle = (state == IDLE);

  assign disp_alarm    = (mode == 2'd2);
  assign time_inc_hour = hour_p & is_idle & (mode == 2'd1);
  assign time_inc_min  = min_p & is_idle & (mode == 2'd1);

  assign match = tick_1hz & (mode == 2'd0) & armed
               & (cur_hour == alarm_hour)
               & (cur_min == alarm_min)
               & (cur_sec == 6'd0);

  // alarm time edits in set-alarm mode; alarm-off disarms
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      alarm_hour <= '0;
      alarm_min  <= '0;
      armed      <= 1'b0;
    end else if (mode == 2'd3) begin
      armed <= 1'b0;
    end else if (is_idle && mode == 2'd2) begin
      if (hour_p)
        alarm_hour <= (alarm_hour == 5'd23) ? 5'd0
                    : alarm_hour + 5'd1;
      if (min_p)
        alarm_min <= (alarm_min == 6'd59) ? 6'd0
                   : alarm_min + 6'd1;
      if (any_p)
        armed <= 1'b1;
    end
  end

  // ring / snooze / dismiss state machine with registered alarm
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      sec_cnt <= '0;
      alarm   <= 1'b0;
    end else if (mode == 2'd3) begin
      state   <= IDLE;
      sec_cnt <= '0;
      alarm   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (match) begin
            state   <= RINGING;
            sec_cnt <= '0;
            alarm   <= 1'b1;
          end
        end
        RINGING: begin
          if (any_p) begin
            state   <= SNOOZE;
            sec_cnt <= '0;
            alarm   <= 1'b0;
          end else if (tick_1hz) begin
            if (sec_cnt == SW'(RING_SECS - 1)) begin
              state   <= IDLE;
              sec_cnt <= '0;
              alarm   <= 1'b0;
            end else begin
              sec_cnt <= sec_cnt + 1'b1;
            end
          end
        end
        SNOOZE: begin
          if (tick_1hz) begin
            if (sec_cnt == SW'(SNOOZE_SECS - 1)) begin
              state   <= RINGING;
              sec_cnt <= '0;
              alarm   <= 1'b1;
            end else begin
              sec_cnt <= sec_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          sec_cnt <= '0;
          alarm   <= 1'b0;
        end
      endcase
    end
  end

endmodule
